// File: rtl/shift_seq32.sv
// Iterative RV32 shifter (SLL/SRL/SRA/pass-through), STEP bit positions per clock.
// Latency: 1 cycle for shamt==0 or pass-through, else 1+ceil(shamt/STEP); result held until out_ready.
// Backpressure: accepts only in IDLE; result is frozen in DONE while out_ready is low; kill aborts.
module shift_seq32 #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] X,
    input  logic [31:0] shift,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
            $error("shift_seq32: STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [4:0] STEP_W  = 5'(STEP);

    state_t      state;
    logic [31:0] work;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [4:0]  k;
    logic [31:0] shifted;

    // Upper shift bits are architecturally ignored (RISC-V uses shamt = shift[4:0]).
    logic unused_shift_hi;
    assign unused_shift_hi = ^shift[31:5];

    always_comb begin
        k = (cnt < STEP_W) ? cnt : STEP_W;
        case (op_q)
            OP_SLL:  shifted = work << k;
            OP_SRL:  shifted = work >> k;
            OP_SRA:  shifted = $signed(work) >>> k;
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !kill) begin
                        work <= X;
                        cnt  <= shift[4:0];
                        op_q <= op;
                        if (shift[4:0] == 5'd0 || op == OP_PASS) begin
                            state  <= DONE;
                            result <= X;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (kill) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        work <= shifted;
                        cnt  <= cnt - k;
                        if (cnt == k) begin
                            state  <= DONE;
                            result <= shifted;
                        end
                    end
                end
                DONE: begin
                    // kill takes priority over a simultaneous out_ready; both end in IDLE.
                    if (kill) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
